pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measures a PWM waveform and recovers its rise time, fall time and full-width flag against the shared TIME_CNT time base.
- This is the inverse of the transducer PWM generator.
- Sits beside the PWM output stage for loopback self-test: it observes the generated PWM_OUT of one channel over one full period and reports the RISE/FALL pair that would produce it.
- Intended for bring-up diagnostics and the regression bench, not the data path.

Parameters:
- WIDTH, 13, width of TIME_CNT and captured values; period is 2^WIDTH clocks.
- LATENCY, 1, pipeline delay in clocks between a TIME_CNT value and the PWM_IN level it produced; legal range 0..4.

Ports:
- CLK  input  1  system clock
- RST_N  input  1  synchronous reset, active-low
- TIME_CNT  input  WIDTH  free-running time base; +1 per clock, wraps at 2^WIDTH-1 -> 0
- PWM_IN  input  1  observed PWM level, same clock domain
- START  input  1  single-cycle request to begin one measurement
- BUSY  output  1  high from the cycle after an accepted START until the VALID cycle, inclusive
- VALID  output  1  one-cycle pulse: result outputs updated
- RISE_OUT  output  WIDTH  captured rise time
- FALL_OUT  output  WIDTH  captured fall time
- FULL_WIDTH_OUT  output  1  signal was constant high for the whole period
- ERR  output  1  waveform was not a single-pulse PWM

Behaviour:
- Alignment: t_a = TIME_CNT delayed by LATENCY registers; LATENCY=0 means t_a = TIME_CNT. p_prev = PWM_IN registered one clock, sampled continuously in every state.
- Edges: rise = PWM_IN & ~p_prev; fall = ~PWM_IN & p_prev. The recorded time of an edge is t_a in the same cycle.
- FSM IDLE -> ARM -> MEASURE -> DONE -> IDLE.
  - IDLE: START=1 -> ARM. START in any other state is ignored.
  - ARM: when t_a == 2^WIDTH-1 -> MEASURE. Clear the edge counters and capture registers on that transition.
  - MEASURE: processes exactly 2^WIDTH samples, t_a = 0 .. 2^WIDTH-1. The sample at t_a=0 compares against p_prev from t_a=2^WIDTH-1 of the previous period.
    - First rise: rise time and level stored. First fall: fall time stored.
    - Rise and fall counters are 2-bit and saturating.
    - On the sample with t_a == 2^WIDTH-1 -> DONE. An edge on this sample is counted.
  - DONE: one cycle. VALID=1; outputs load from classification; next state IDLE.
- Classification, evaluated in DONE:
  - rises=1 and falls=1: RISE_OUT/FALL_OUT = stored times, FULL_WIDTH_OUT=0, ERR=0. Covers both R<F and wrapped R>F.
  - rises=0 and falls=0, level high: FULL_WIDTH_OUT=1, RISE_OUT=FALL_OUT=0, ERR=0.
  - rises=0 and falls=0, level low: FULL_WIDTH_OUT=0, RISE_OUT=FALL_OUT=0, ERR=0.
  - Any other count combination: ERR=1, FULL_WIDTH_OUT=0, RISE_OUT/FALL_OUT = first recorded times (0 if none).
- Result outputs are registered and hold their value until the next VALID.
- Latency: VALID is asserted exactly 1 clock after the MEASURE sample with t_a = 2^WIDTH-1.
  - Worst case START -> VALID ≈ 2·2^WIDTH + 2 clocks.
- Reset (RST_N=0), including mid-ARM or mid-MEASURE:
  - Next edge: state IDLE, BUSY=0, VALID=0, RISE_OUT=0, FALL_OUT=0, FULL_WIDTH_OUT=0, ERR=0.
  - Counters and delay line cleared; no VALID is issued for the aborted measurement.
- Reset and START in the same cycle: reset wins.
- A rise and a fall cannot coincide in one sample. Sub-clock glitches are not observable; a 1-clock pulse counts as one rise and one fall.

Optional Feature:
- Macro: PWM_CAPTURE_CONTINUOUS_EN.
- Defined: DONE transitions directly to MEASURE instead of IDLE. Counters are cleared on entry, so every subsequent period produces a VALID pulse with no START needed; BUSY stays high. START is ignored while looping. Reset returns to IDLE.
- Undefined: single-shot behaviour exactly as above.

Test Plan:
- WIDTH=8, LATENCY=1, generator R=10, F=100, START -> single VALID; RISE_OUT=10, FALL_OUT=100, FULL_WIDTH_OUT=0, ERR=0; BUSY low the cycle after VALID.
- R=200, F=50 (wrapped pulse) -> RISE_OUT=200, FALL_OUT=50, ERR=0. Also R=0, F=128 -> RISE_OUT=0, FALL_OUT=128 (edge at t_a=0 detected).
- PWM_IN held 1 -> FULL_WIDTH_OUT=1, RISE_OUT=0, FALL_OUT=0, ERR=0. PWM_IN held 0 -> all result outputs 0, ERR=0.
- R=10, F=100 plus an injected extra high pulse at t=150..152 -> ERR=1, RISE_OUT=10, FALL_OUT=100.
- START, then RST_N=0 for 1 clock at t_a=60 in MEASURE -> BUSY=0 next cycle, no VALID for 600 clocks. START pulses while BUSY -> no second measurement queued; exactly one VALID.
- PWM_CAPTURE_CONTINUOUS_EN defined, R=30, F=40 -> one START yields VALID every 256 clocks, each with RISE_OUT=30, FALL_OUT=40. Changing F to 90 mid-run -> the first full period after the change reports 90.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture block and whoever drives its time base,
// observed waveform and start request.
interface pwm_capture_if #(
  parameter int WIDTH = 13
);
  logic [WIDTH-1:0] TIME_CNT;
  logic             PWM_IN;
  logic             START;
  logic             BUSY;
  logic             VALID;
  logic [WIDTH-1:0] RISE_OUT;
  logic [WIDTH-1:0] FALL_OUT;
  logic             FULL_WIDTH_OUT;
  logic             ERR;

  modport master (
    output TIME_CNT, PWM_IN, START,
    input  BUSY, VALID, RISE_OUT, FALL_OUT, FULL_WIDTH_OUT, ERR
  );

  modport slave (
    input  TIME_CNT, PWM_IN, START,
    output BUSY, VALID, RISE_OUT, FALL_OUT, FULL_WIDTH_OUT, ERR
  );
endinterface

// File: rtl/pwm_capture.sv
// Recovers rise/fall times of one PWM period against the shared time base.
// Define PWM_CAPTURE_CONTINUOUS_EN to re-measure every period after one START.
module pwm_capture #(
  parameter int WIDTH   = 13,
  parameter int LATENCY = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  pwm_capture_if.slave  bus
);
  localparam logic [WIDTH-1:0] T_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] t_a;
  logic             p_prev_reg;
  logic [1:0]       rise_cnt_reg, rise_cnt_next;
  logic [1:0]       fall_cnt_reg, fall_cnt_next;
  logic [WIDTH-1:0] rise_time_reg, rise_time_next;
  logic [WIDTH-1:0] fall_time_reg, fall_time_next;
  logic [WIDTH-1:0] rise_out_reg, fall_out_reg;
  logic             full_out_reg, err_out_reg;
  logic [WIDTH-1:0] cls_rise, cls_fall;
  logic             cls_full, cls_err;
  logic             rise_edge, fall_edge;
  logic             busy, valid, proc, clear, last_sample;

  // Align the time base with the pipeline that produced PWM_IN.
  if (LATENCY == 0) begin : g_no_dly
    assign t_a = bus.TIME_CNT;
  end else begin : g_dly
    logic [WIDTH-1:0] dly_reg [LATENCY];
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        for (int i = 0; i < LATENCY; i++) dly_reg[i] <= '0;
      end else begin
        dly_reg[0] <= bus.TIME_CNT;
        for (int i = 1; i < LATENCY; i++) dly_reg[i] <= dly_reg[i-1];
      end
    end
    assign t_a = dly_reg[LATENCY-1];
  end

  assign rise_edge = bus.PWM_IN & ~p_prev_reg;
  assign fall_edge = ~bus.PWM_IN & p_prev_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b1;
    valid       = 1'b0;
    proc        = 1'b0;
    clear       = 1'b0;
    last_sample = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.START) state_next = S_ARM;
      end
      S_ARM: begin
        if (t_a == T_MAX) begin
          state_next = S_MEASURE;
          clear      = 1'b1;
        end
      end
      S_MEASURE: begin
        proc = 1'b1;
        if (t_a == T_MAX) begin
          state_next  = S_DONE;
          last_sample = 1'b1;
          clear       = 1'b1;
        end
      end
      S_DONE: begin
        valid = 1'b1;
`ifdef PWM_CAPTURE_CONTINUOUS_EN
        // The DONE cycle carries the t_a=0 sample of the next period.
        state_next = S_MEASURE;
        proc       = 1'b1;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rise_cnt_next  = rise_cnt_reg;
    fall_cnt_next  = fall_cnt_reg;
    rise_time_next = rise_time_reg;
    fall_time_next = fall_time_reg;
    if (rise_edge) begin
      if (rise_cnt_reg == 2'd0) rise_time_next = t_a;
      if (rise_cnt_reg != 2'd3) rise_cnt_next  = rise_cnt_reg + 2'd1;
    end
    if (fall_edge) begin
      if (fall_cnt_reg == 2'd0) fall_time_next = t_a;
      if (fall_cnt_reg != 2'd3) fall_cnt_next  = fall_cnt_reg + 2'd1;
    end
  end

  // Classify from the next-state counts so the final sample's edge is included.
  always_comb begin
    cls_rise = '0;
    cls_fall = '0;
    cls_full = 1'b0;
    cls_err  = 1'b0;
    if (rise_cnt_next == 2'd1 && fall_cnt_next == 2'd1) begin
      cls_rise = rise_time_next;
      cls_fall = fall_time_next;
    end else if (rise_cnt_next == 2'd0 && fall_cnt_next == 2'd0) begin
      cls_full = bus.PWM_IN;
    end else begin
      cls_err  = 1'b1;
      cls_rise = rise_time_next;
      cls_fall = fall_time_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      p_prev_reg    <= 1'b0;
      rise_cnt_reg  <= '0;
      fall_cnt_reg  <= '0;
      rise_time_reg <= '0;
      fall_time_reg <= '0;
      rise_out_reg  <= '0;
      fall_out_reg  <= '0;
      full_out_reg  <= 1'b0;
      err_out_reg   <= 1'b0;
    end else begin
      p_prev_reg <= bus.PWM_IN;
      if (last_sample) begin
        rise_out_reg <= cls_rise;
        fall_out_reg <= cls_fall;
        full_out_reg <= cls_full;
        err_out_reg  <= cls_err;
      end
      if (clear) begin
        rise_cnt_reg  <= '0;
        fall_cnt_reg  <= '0;
        rise_time_reg <= '0;
        fall_time_reg <= '0;
      end else if (proc) begin
        rise_cnt_reg  <= rise_cnt_next;
        fall_cnt_reg  <= fall_cnt_next;
        rise_time_reg <= rise_time_next;
        fall_time_reg <= fall_time_next;
      end
    end
  end

  assign bus.BUSY           = busy;
  assign bus.VALID          = valid;
  assign bus.RISE_OUT       = rise_out_reg;
  assign bus.FALL_OUT       = fall_out_reg;
  assign bus.FULL_WIDTH_OUT = full_out_reg;
  assign bus.ERR            = err_out_reg;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: WIDTH=8, LATENCY=1, queue-based period model plus directed cases.
module tb_pwm_capture;
  localparam int W = 8;
  localparam int N = 256;
`ifdef PWM_CAPTURE_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_COLL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pwm_capture_if #(.WIDTH(W)) bus_if ();

  pwm_capture #(.WIDTH(W), .LATENCY(1)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Generator: mode 0 = pulse R..F (wrapping), 1 = held high, 2 = held low.
  int g_mode  = 2;
  int g_r     = 0;
  int g_f     = 0;
  bit g_extra = 1'b0;

  function automatic logic gen_level(logic [7:0] t);
    int  ti;
    logic lv;
    ti = int'(t);
    if (g_mode == 1)      lv = 1'b1;
    else if (g_mode == 2) lv = 1'b0;
    else if (g_r < g_f)   lv = (ti >= g_r) && (ti < g_f);
    else                  lv = (ti >= g_r) || (ti < g_f);
    if (g_extra && ti >= 150 && ti <= 152) lv = 1'b1;
    return lv;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_line(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Time base and PWM stimulus: PWM_IN lags TIME_CNT by one clock.
  initial begin
    bus_if.TIME_CNT = '0;
    bus_if.PWM_IN   = 1'b0;
    forever begin
      @(negedge clk);
      bus_if.PWM_IN   = gen_level(bus_if.TIME_CNT);
      bus_if.TIME_CNT = bus_if.TIME_CNT + 8'd1;
    end
  end

  // Model: gather the edge lists of one whole period and classify them.
  logic [7:0] m_ta;
  logic       m_lvl;
  logic       m_prev = 1'b0;
  int         m_phase = P_IDLE;
  int         rq[$];
  int         fq[$];
  int         e_rise = 0, e_fall = 0, e_full = 0, e_err = 0;
  bit         e_valid, e_busy;

  always @(posedge clk) begin
    #1;
    m_ta    = bus_if.TIME_CNT - 8'd1;
    m_lvl   = bus_if.PWM_IN;
    e_valid = 1'b0;
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_prev  = 1'b0;
      e_rise  = 0;
      e_fall  = 0;
      e_full  = 0;
      e_err   = 0;
      rq.delete();
      fq.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (bus_if.START) m_phase = P_WAIT;
        P_WAIT: if (m_ta == 8'hFF) begin
          m_phase = P_COLL;
          rq.delete();
          fq.delete();
        end
        default: begin
          if (m_lvl && !m_prev) rq.push_back(int'(m_ta));
          if (!m_lvl && m_prev) fq.push_back(int'(m_ta));
          if (m_ta == 8'hFF) begin
            if (rq.size() == 1 && fq.size() == 1) begin
              e_rise = rq[0]; e_fall = fq[0]; e_full = 0; e_err = 0;
            end else if (rq.size() == 0 && fq.size() == 0) begin
              e_rise = 0; e_fall = 0; e_full = int'(m_lvl); e_err = 0;
            end else begin
              e_rise = (rq.size() > 0) ? rq[0] : 0;
              e_fall = (fq.size() > 0) ? fq[0] : 0;
              e_full = 0;
              e_err  = 1;
            end
            e_valid = 1'b1;
            rq.delete();
            fq.delete();
            if (!CONT) m_phase = P_IDLE;
          end
        end
      endcase
      m_prev = m_lvl;
    end
    e_busy = (m_phase != P_IDLE) || e_valid;
    check("busy",     int'(bus_if.BUSY),           int'(e_busy));
    check("valid",    int'(bus_if.VALID),          int'(e_valid));
    check("rise_out", int'(bus_if.RISE_OUT),       e_rise);
    check("fall_out", int'(bus_if.FALL_OUT),       e_fall);
    check("full_out", int'(bus_if.FULL_WIDTH_OUT), e_full);
    check("err",      int'(bus_if.ERR),            e_err);
  end

  task automatic settle();
    repeat (N + 4) @(negedge clk);
  endtask

  task automatic set_pulse(int r, int f, bit extra);
    g_mode = 0; g_r = r; g_f = f; g_extra = extra;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus_if.START = 1'b1;
    @(negedge clk);
    bus_if.START = 1'b0;
  endtask

  task automatic wait_valid(int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.VALID) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_line("wait_valid");
  endtask

  task automatic wait_tc(logic [7:0] v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.TIME_CNT == v) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_line("wait_tc");
  endtask

  task automatic measure(string name, int r, int f, int fw, int err);
    bit got;
    pulse_start();
    wait_valid(600, got);
    if (got) begin
      check({name, "_rise"}, int'(bus_if.RISE_OUT),       r);
      check({name, "_fall"}, int'(bus_if.FALL_OUT),       f);
      check({name, "_full"}, int'(bus_if.FULL_WIDTH_OUT), fw);
      check({name, "_err"},  int'(bus_if.ERR),            err);
      @(posedge clk);
      #1;
      check({name, "_busy_after"}, int'(bus_if.BUSY), 0);
    end
    $display("txn %s: rise=%0d fall=%0d full=%0d err=%0d", name, bus_if.RISE_OUT,
             bus_if.FALL_OUT, bus_if.FULL_WIDTH_OUT, bus_if.ERR);
  endtask

  task automatic run_single();
    int nv;
    set_pulse(10, 100, 1'b0);   settle(); measure("basic",   10, 100, 0, 0);
    set_pulse(200, 50, 1'b0);   settle(); measure("wrapped", 200, 50, 0, 0);
    set_pulse(0, 128, 1'b0);    settle(); measure("edge0",   0, 128, 0, 0);
    g_mode = 1; g_extra = 1'b0; settle(); measure("high",    0, 0, 1, 0);
    g_mode = 2;                 settle(); measure("low",     0, 0, 0, 0);
    set_pulse(10, 100, 1'b1);   settle(); measure("extra",   10, 100, 0, 1);

    // Reset during MEASURE aborts the measurement silently.
    set_pulse(10, 100, 1'b0); settle();
    pulse_start();
    wait_tc(8'd0);
    wait_tc(8'd61);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("rst_busy", int'(bus_if.BUSY), 0);
    nv = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus_if.VALID) nv++;
    end
    check("rst_no_valid", nv, 0);
    $display("txn reset_abort: valids=%0d", nv);

    // Extra STARTs while busy must not queue a second measurement.
    nv = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (bus_if.VALID) nv++;
      bus_if.START = (i == 0 || i == 20 || i == 100 || i == 200);
    end
    bus_if.START = 1'b0;
    check("single_valid", nv, 1);
    $display("txn multi_start: valids=%0d", nv);
  endtask

  task automatic run_cont();
    bit got;
    set_pulse(30, 40, 1'b0); settle();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_valid(600, got);
      if (got) begin
        check("cont_rise", int'(bus_if.RISE_OUT), 30);
        check("cont_fall", int'(bus_if.FALL_OUT), 40);
        @(posedge clk);
        #1;
        check("cont_busy", int'(bus_if.BUSY), 1);
      end
      $display("txn cont%0d: rise=%0d fall=%0d", k, bus_if.RISE_OUT, bus_if.FALL_OUT);
    end
    g_f = 90;
    wait_valid(300, got);
    wait_valid(300, got);
    if (got) begin
      check("cont_new_rise", int'(bus_if.RISE_OUT), 30);
      check("cont_new_fall", int'(bus_if.FALL_OUT), 90);
    end
    $display("txn cont_f90: rise=%0d fall=%0d", bus_if.RISE_OUT, bus_if.FALL_OUT);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("cont_rst_busy", int'(bus_if.BUSY), 0);
  endtask

  initial begin
    bus_if.START = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    check("reset_busy",  int'(bus_if.BUSY),           0);
    check("reset_valid", int'(bus_if.VALID),          0);
    check("reset_rise",  int'(bus_if.RISE_OUT),       0);
    check("reset_fall",  int'(bus_if.FALL_OUT),       0);
    check("reset_full",  int'(bus_if.FULL_WIDTH_OUT), 0);
    check("reset_err",   int'(bus_if.ERR),            0);
    if (CONT) run_cont();
    else      run_single();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
